// File: rtl/ascon_ctrl.sv
// Sequencing controller for an Ascon-128 datapath: init, associated data,
// plaintext and finalisation phases with a shared 4-bit round counter.
module ascon_ctrl (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic       data_ready_o,
  output logic       selectionp_o,
  output logic       enable_o,
  output logic       bypass_begin_o,
  output logic       mode_int_ext_o,
  output logic       bypass_end_o,
  output logic       mode_init_data_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic [3:0] round_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE
  } state_t;

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       last, last_n;
  logic       cipher_valid_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state          <= IDLE;
      cnt            <= '0;
      last           <= 1'b0;
      cipher_valid_q <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      last           <= last_n;
      cipher_valid_q <= en_cipher_o;
    end
  end

  assign cipher_valid_o = cipher_valid_q;

  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    last_n           = last;
    data_ready_o     = 1'b0;
    selectionp_o     = 1'b1;
    enable_o         = 1'b0;
    bypass_begin_o   = 1'b1;
    mode_int_ext_o   = 1'b0;
    bypass_end_o     = 1'b1;
    mode_init_data_o = 1'b0;
    en_cipher_o      = 1'b0;
    en_tag_o         = 1'b0;
    round_o          = '0;
    tag_valid_o      = 1'b0;
    busy_o           = 1'b1;

    case (state)
      // IDLE drives selectionp low so the reset/idle output image is all-zero
      // apart from the two bypass controls; enable is low so it is harmless.
      IDLE: begin
        selectionp_o = 1'b0;
        busy_o       = 1'b0;
        if (start_i) begin
          state_n = INIT;
          cnt_n   = '0;
        end
      end
      INIT: begin
        enable_o = 1'b1;
        round_o  = cnt;
        if (cnt == 4'd0) selectionp_o = 1'b0;
        if (cnt == 4'd11) begin
          bypass_end_o = 1'b0;
          state_n      = WAIT_AD;
          cnt_n        = '0;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      WAIT_AD: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          last_n  = data_last_i;
          cnt_n   = '0;
          state_n = AD;
        end
      end
      AD: begin
        enable_o = 1'b1;
        round_o  = cnt + 4'd6;
        if (cnt == 4'd0) bypass_begin_o = 1'b0;
        if (cnt == 4'd5) begin
          if (last) begin
            bypass_end_o     = 1'b0;
            mode_init_data_o = 1'b1;
          end
          cnt_n   = '0;
          state_n = last ? WAIT_PT : WAIT_AD;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      WAIT_PT: begin
        data_ready_o = 1'b1;
        if (data_valid_i) begin
          last_n  = data_last_i;
          cnt_n   = '0;
          state_n = data_last_i ? FINAL : PT;
        end
      end
      PT: begin
        enable_o = 1'b1;
        round_o  = cnt + 4'd6;
        if (cnt == 4'd0) begin
          bypass_begin_o = 1'b0;
          en_cipher_o    = 1'b1;
        end
        if (cnt == 4'd5) begin
          cnt_n   = '0;
          state_n = WAIT_PT;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      FINAL: begin
        enable_o = 1'b1;
        round_o  = cnt;
        if (cnt == 4'd0) begin
          bypass_begin_o = 1'b0;
          mode_int_ext_o = 1'b1;
          en_cipher_o    = 1'b1;
        end
        if (cnt == 4'd11) begin
          bypass_end_o = 1'b0;
          en_tag_o     = 1'b1;
          cnt_n        = '0;
          state_n      = DONE;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      DONE: begin
        tag_valid_o = 1'b1;
        state_n     = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl.sv
// Directed bench for ascon_ctrl: per-cycle expected output images for whole
// messages, plus reset and abort scenarios.
module tb_ascon_ctrl;

  logic       clock_i = 1'b0;
  logic       reset_i, start_i, data_valid_i, data_last_i;
  logic       data_ready_o, selectionp_o, enable_o, bypass_begin_o;
  logic       mode_int_ext_o, bypass_end_o, mode_init_data_o;
  logic       en_cipher_o, en_tag_o, cipher_valid_o, tag_valid_o, busy_o;
  logic [3:0] round_o;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       data_ready, selectionp, enable, bypass_begin, mode_int_ext;
    logic       bypass_end, mode_init_data, en_cipher, en_tag;
    logic [3:0] round;
    logic       cipher_valid, tag_valid, busy;
  } outs_t;

  typedef struct packed {
    outs_t e;
    logic  s, v, l;
  } cyc_t;

  outs_t obs;
  assign obs = '{data_ready_o, selectionp_o, enable_o, bypass_begin_o,
                 mode_int_ext_o, bypass_end_o, mode_init_data_o, en_cipher_o,
                 en_tag_o, round_o, cipher_valid_o, tag_valid_o, busy_o};

  ascon_ctrl dut (
    .clock_i(clock_i), .reset_i(reset_i), .start_i(start_i),
    .data_valid_i(data_valid_i), .data_last_i(data_last_i),
    .data_ready_o(data_ready_o), .selectionp_o(selectionp_o),
    .enable_o(enable_o), .bypass_begin_o(bypass_begin_o),
    .mode_int_ext_o(mode_int_ext_o), .bypass_end_o(bypass_end_o),
    .mode_init_data_o(mode_init_data_o), .en_cipher_o(en_cipher_o),
    .en_tag_o(en_tag_o), .round_o(round_o), .cipher_valid_o(cipher_valid_o),
    .tag_valid_o(tag_valid_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic outs_t idle_o();
    outs_t o;
    o = '0;
    o.bypass_begin = 1'b1;
    o.bypass_end   = 1'b1;
    return o;
  endfunction

  function automatic outs_t act_o();
    outs_t o;
    o = idle_o();
    o.selectionp = 1'b1;
    o.busy       = 1'b1;
    return o;
  endfunction

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  // Whole message from the IDLE cycle carrying start through DONE.
  // vh holds data_valid/data_last high throughout (single AD + single PT).
  task automatic run_msg(input string name, input int n_ad, input int n_pt,
                         input int gap, input logic hold, input logic vh);
    cyc_t q[$];
    cyc_t c;
    int   n_cv = 0;
    int   n_tv = 0;
    c.e = idle_o(); c.s = 1'b1; c.v = vh; c.l = vh; q.push_back(c);
    c.s = hold;
    for (int k = 0; k < 12; k++) begin
      c.e = act_o(); c.e.enable = 1'b1; c.e.round = 4'(k);
      if (k == 0)  c.e.selectionp = 1'b0;
      if (k == 11) c.e.bypass_end = 1'b0;
      q.push_back(c);
    end
    for (int b = 0; b < n_ad; b++) begin
      for (int g = 0; g < gap; g++) begin
        c.e = act_o(); c.e.data_ready = 1'b1; c.v = vh; c.l = vh; q.push_back(c);
      end
      c.e = act_o(); c.e.data_ready = 1'b1; c.v = 1'b1;
      c.l = vh | (b == n_ad - 1); q.push_back(c);
      c.v = vh; c.l = vh;
      for (int k = 0; k < 6; k++) begin
        c.e = act_o(); c.e.enable = 1'b1; c.e.round = 4'(6 + k);
        if (k == 0) c.e.bypass_begin = 1'b0;
        if (k == 5 && b == n_ad - 1) begin
          c.e.bypass_end = 1'b0; c.e.mode_init_data = 1'b1;
        end
        q.push_back(c);
      end
    end
    for (int b = 0; b < n_pt; b++) begin
      for (int g = 0; g < gap; g++) begin
        c.e = act_o(); c.e.data_ready = 1'b1; c.v = vh; c.l = vh; q.push_back(c);
      end
      c.e = act_o(); c.e.data_ready = 1'b1; c.v = 1'b1;
      c.l = vh | (b == n_pt - 1); q.push_back(c);
      c.v = vh; c.l = vh;
      for (int k = 0; k < ((b == n_pt - 1) ? 12 : 6); k++) begin
        c.e = act_o(); c.e.enable = 1'b1;
        c.e.round = (b == n_pt - 1) ? 4'(k) : 4'(6 + k);
        if (k == 0) begin
          c.e.bypass_begin = 1'b0; c.e.en_cipher = 1'b1;
          c.e.mode_int_ext = (b == n_pt - 1);
        end
        if (k == 1) c.e.cipher_valid = 1'b1;
        if (k == 11) begin
          c.e.bypass_end = 1'b0; c.e.en_tag = 1'b1;
        end
        q.push_back(c);
      end
    end
    c.e = act_o(); c.e.tag_valid = 1'b1; q.push_back(c);

    foreach (q[i]) begin
      start_i = q[i].s; data_valid_i = q[i].v; data_last_i = q[i].l;
      #1;
      tests++;
      if (obs !== q[i].e) begin
        fails++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, obs, q[i].e);
      end
      if (cipher_valid_o === 1'b1) n_cv++;
      if (tag_valid_o === 1'b1) n_tv++;
      step();
    end
    data_valid_i = 1'b0; data_last_i = 1'b0;
    tests++;
    if (n_cv !== n_pt) begin
      fails++;
      $display("FAIL %s cipher_valid pulses: got %0d expected %0d", name, n_cv, n_pt);
    end
    tests++;
    if (n_tv !== 1) begin
      fails++;
      $display("FAIL %s tag_valid pulses: got %0d expected 1", name, n_tv);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; start_i = 1'b0; data_valid_i = 1'b0; data_last_i = 1'b0;
    #3;
    tests++;
    if (obs !== idle_o()) begin
      fails++;
      $display("FAIL reset outputs: got %h expected %h", obs, idle_o());
    end
    step();
    reset_i = 1'b0;
    step();
    tests++;
    if (obs !== idle_o()) begin
      fails++;
      $display("FAIL idle after reset: got %h expected %h", obs, idle_o());
    end
  endtask

  task automatic test_basic();
    run_msg("basic", 1, 1, 0, 1'b0, 1'b1);
  endtask

  task automatic test_multi_block();
    run_msg("multi", 2, 3, 3, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_msg("held_start", 1, 1, 0, 1'b1, 1'b0);
    run_msg("second_msg", 1, 2, 1, 1'b0, 1'b0);
  endtask

  task automatic test_abort_final();
    int seen = 0;
    start_i = 1'b1; data_valid_i = 1'b1; data_last_i = 1'b1;
    step();
    start_i = 1'b0;
    repeat (25) step();
    tests++;
    if (round_o !== 4'd5 || enable_o !== 1'b1 || en_tag_o !== 1'b0) begin
      fails++;
      $display("FAIL abort precondition: got round %0d enable %b expected round 5 enable 1",
               round_o, enable_o);
    end
    #2 reset_i = 1'b1;
    #1;
    tests++;
    if (obs !== idle_o()) begin
      fails++;
      $display("FAIL abort reset outputs: got %h expected %h", obs, idle_o());
    end
    data_valid_i = 1'b0; data_last_i = 1'b0;
    step();
    reset_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cipher_valid_o !== 1'b0 || tag_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
      step();
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL abort quiet: got %0d active cycles expected 0", seen);
    end
    run_msg("after_abort", 1, 1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_final_idle();
    tests++;
    if (obs !== idle_o()) begin
      fails++;
      $display("FAIL final idle: got %h expected %h", obs, idle_o());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multi_block();
    test_back_to_back();
    test_abort_final();
    test_final_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ascon_ctrl.md
ASCON_CTRL -- requirements
Module: ascon_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; ports, in order:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin one encryption; sampled in IDLE only
- data_valid_i  in  1  upstream 64-bit block (padded) present on datapath data_i
- data_last_i  in  1  qualifies data_valid_i; last block of current phase (AD or PT)
- data_ready_o  out  1  controller accepts a block
- selectionp_o  out  1  0: datapath loads IV/key/nonce; 1: loads state register
- enable_o  out  1  state register write enable
- bypass_begin_o  out  1  1: input XOR passes state; 0: applies XOR per mode_int_ext_o
- mode_int_ext_o  out  1  0: data into word0; 1: data into word0 plus key into words 1,2
- bypass_end_o  out  1  1: output XOR passes; 0: applies XOR per mode_init_data_o
- mode_init_data_o  out  1  0: key into words 3,4; 1: domain-separation constant 1 into word4
- en_cipher_o  out  1  capture ciphertext block
- en_tag_o  out  1  capture tag
- round_o  out  4  round-constant index to datapath
- cipher_valid_o  out  1  captured ciphertext valid
- tag_valid_o  out  1  captured tag valid
- busy_o  out  1  high in every state except IDLE
REQ-002 The module SHALL have no parameters; a=12 and b=6 rounds are fixed.

Function
REQ-003 States SHALL be IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE; outputs decoded from state and a 4-bit round counter.
REQ-004 IDLE: start_i=1 SHALL go to INIT with counter=0; otherwise stay.
REQ-005 INIT: 12 cycles, round_o=0..11, enable_o=1; cycle 0 selectionp_o=0, bypass_begin_o=1; cycles 1-11 selectionp_o=1, bypass_begin_o=1; cycle 11 bypass_end_o=0, mode_init_data_o=0; then WAIT_AD.
REQ-006 WAIT_AD/WAIT_PT: data_ready_o=1, enable_o=0; transfer when data_valid_i&data_ready_o; data_last_i latched at transfer.
REQ-007 AD: 6 cycles, round_o=6..11, selectionp_o=1, enable_o=1; cycle 0 bypass_begin_o=0, mode_int_ext_o=0; if latched last, cycle 5 bypass_end_o=0, mode_init_data_o=1; next WAIT_PT if last, else WAIT_AD.
REQ-008 At least one AD block SHALL be supplied (upstream pads empty AD); at least one PT block likewise.
REQ-009 PT transfer with last=0 SHALL go to PT: 6 cycles, round_o=6..11; cycle 0 bypass_begin_o=0, mode_int_ext_o=0, en_cipher_o=1; then WAIT_PT.
REQ-010 PT transfer with last=1 SHALL go to FINAL: 12 cycles, round_o=0..11; cycle 0 bypass_begin_o=0, mode_int_ext_o=1, en_cipher_o=1; cycle 11 bypass_end_o=0, mode_init_data_o=0, en_tag_o=1; then DONE.
REQ-011 DONE: one cycle, enable_o=0, then IDLE.
REQ-012 cipher_valid_o SHALL pulse one cycle, the cycle after en_cipher_o=1; tag_valid_o SHALL pulse one cycle in DONE.
REQ-013 Outside listed cycles: bypass_begin_o=1, bypass_end_o=1, mode_*=0, en_*=0, data_ready_o=0, selectionp_o=1 (except INIT cycle 0).
REQ-014 start_i outside IDLE and data_valid_i outside WAIT states SHALL be ignored.
REQ-015 Round counter SHALL wrap only by state exit; it never exceeds 11.

Reset
REQ-016 reset_i=1 SHALL immediately force IDLE, counter=0, latched last=0, all outputs 0 except bypass_begin_o=1, bypass_end_o=1.
REQ-017 Reset mid-operation SHALL abort the message with no cipher_valid_o/tag_valid_o afterwards; next start_i begins fresh INIT.

Verification
REQ-018 start at cycle 0 -> INIT cycles 1-12, round_o 0..11, selectionp_o=0 only cycle 1, bypass_end_o=0 only cycle 12, data_ready_o=1 cycle 13.
REQ-019 One AD (last) accepted cycle 13, one PT (last) accepted cycle 20 -> AD cycles 14-19 with mode_init_data_o=1 at 19; FINAL cycles 21-32, en_cipher_o at 21, en_tag_o at 32, tag_valid_o at 33, busy_o=0 at 34.
REQ-020 Two AD blocks, three PT blocks, data_valid_i delayed 3 cycles each -> WAIT states hold enable_o=0; domain separation only after second AD; three cipher_valid_o pulses; one tag_valid_o.
REQ-021 start_i held high throughout a message -> no restart until IDLE; second message starts the cycle after DONE's IDLE.
REQ-022 reset_i pulsed during FINAL round 5 -> all outputs at reset values same cycle; no tag_valid_o; clean message afterwards.
REQ-023 data_valid_i asserted during INIT/AD -> no transfer, data_ready_o=0, sequence unaffected.
